// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default bit timing,
// common to the transmitter and receiver.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 48;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4,
    PARITY    = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; the reset value
// should match the input's idle level so reset does not look like an edge.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 with mid-bit sampling. Define UART_RX_PARITY_EN for 8E1
// framing with an extra PARITY state and a parity_err strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  logic rx_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  uart_state_e          state_q;
  logic [CW-1:0]        bit_cnt_q;
  logic [IW-1:0]        bit_idx_q;
  logic [DATA_BITS-1:0] shreg_q, data_q;
  logic                 valid_q, frame_err_q, busy_q;
  logic                 par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_q, parity_err_q;
  assign par_bad    = (^shreg_q) ^ par_q;
  assign parity_err = parity_err_q;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: if (!rx_s) begin
          state_q   <= START;
          bit_cnt_q <= '0;
          busy_q    <= 1'b1;
        end
        // A start bit that is already gone at mid-bit is treated as a glitch.
        START: if (bit_cnt_q == HALF_M1) begin
          bit_cnt_q <= '0;
          bit_idx_q <= '0;
          if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= DATA;
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + CW'(1);
        end
        // LSB arrives first, so shifting in from the top leaves it at bit 0.
        DATA: if (bit_cnt_q == FULL_M1) begin
          bit_cnt_q <= '0;
          shreg_q   <= {rx_s, shreg_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
            state_q   <= PARITY;
`else
            state_q   <= STOP;
`endif
          end else begin
            bit_idx_q <= bit_idx_q + IW'(1);
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + CW'(1);
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (bit_cnt_q == FULL_M1) begin
          bit_cnt_q <= '0;
          par_q     <= rx_s;
          state_q   <= STOP;
        end else begin
          bit_cnt_q <= bit_cnt_q + CW'(1);
        end
`endif
        STOP: if (bit_cnt_q == FULL_M1) begin
          bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
          parity_err_q <= par_bad;
`endif
          if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (!par_bad) begin
              data_q  <= shreg_q;
              valid_q <= 1'b1;
            end
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= WAIT_IDLE;
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + CW'(1);
        end
        // Hold off on a break so a long low line is not seen as new starts.
        WAIT_IDLE: if (rx_s) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule
